// File: rtl/adpcm_code_unpacker.sv
// adpcm_code_unpacker: MSB-first serial G.726 code-word deserializer with output FIFO (ADPCM_UNPACK_CNT_EN adds word_cnt)
module adpcm_code_unpacker #(
    parameter int FIFO_DEPTH = 2,
    parameter int IW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    rate,
    input  logic          ser_bit,
    input  logic          ser_valid,
    input  logic          frame_sync,
    output logic [IW-1:0] I,
    output logic          i_valid,
    input  logic          i_ready,
    output logic          sync_err,
    output logic          overflow
`ifdef ADPCM_UNPACK_CNT_EN
    ,
    output logic [15:0]   word_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {HUNT, SHIFT} state_t;

    state_t        state_q, state_d;
    logic [1:0]    rate_q, rate_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [IW-2:0] sh_q, sh_d;
    logic [2:0]    nb;
    logic          push, err;
    logic [IW-1:0] word;

    logic [IW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [CW-1:0] count_q, count_d;
    logic          full, pop, push_ok, drop;
    logic          sync_err_q, overflow_q;

    assign nb = {1'b0, rate_q} + 3'd2;

    // Deserializer: hunt for frame_sync, then shift contiguous words and flag mid-word resyncs
    always_comb begin
        state_d = state_q;
        rate_d  = rate_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        push    = 1'b0;
        err     = 1'b0;
        word    = {sh_q, ser_bit};
        if (ser_valid && frame_sync) begin
            state_d = SHIFT;
            rate_d  = rate;
            sh_d    = (IW-1)'(ser_bit);
            cnt_d   = 3'd1;
            err     = cnt_q != 3'd0;
        end else if (ser_valid && state_q == SHIFT) begin
            if (cnt_q + 3'd1 == nb) begin
                push  = 1'b1;
                cnt_d = 3'd0;
                sh_d  = '0;
            end else begin
                cnt_d = cnt_q + 3'd1;
                sh_d  = {sh_q[IW-3:0], ser_bit};
            end
        end
    end

    assign full    = count_q == CW'(FIFO_DEPTH);
    assign pop     = i_valid && i_ready;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign count_d = count_q + CW'(push_ok) - CW'(pop);

    // Deserializer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HUNT;
            rate_q     <= 2'b00;
            cnt_q      <= 3'd0;
            sh_q       <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rate_q     <= rate_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            sync_err_q <= err;
        end
    end

    // Output FIFO; a push into a full FIFO lands only when the head is popped in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wp_q] <= word;
                wp_q        <= wp_q + AW'(1);
            end
            if (pop) rp_q <= rp_q + AW'(1);
            count_q <= count_d;
            if (drop) overflow_q <= 1'b1;
        end
    end

`ifdef ADPCM_UNPACK_CNT_EN
    // Count words actually accepted into the FIFO
    always_ff @(posedge clk) begin
        if (reset) word_cnt <= 16'd0;
        else if (push_ok) word_cnt <= word_cnt + 16'd1;
    end
`endif

    assign I        = mem_q[rp_q];
    assign i_valid  = count_q != '0;
    assign sync_err = sync_err_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_adpcm_code_unpacker.sv
// tb_adpcm_code_unpacker: directed checks of the ADPCM code-word unpacker
module tb_adpcm_code_unpacker;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  rate = 2'b00;
    logic        ser_bit = 1'b0;
    logic        ser_valid = 1'b0;
    logic        frame_sync = 1'b0;
    logic [4:0]  I;
    logic        i_valid;
    logic        i_ready = 1'b0;
    logic        sync_err;
    logic        overflow;
`ifdef ADPCM_UNPACK_CNT_EN
    logic [15:0] word_cnt;
`endif

    int tests = 0;
    int fails = 0;
    int errs = 0;
    logic [31:0] q[$];

    adpcm_code_unpacker #(.FIFO_DEPTH(2), .IW(5)) dut (
        .clk(clk), .reset(reset), .rate(rate), .ser_bit(ser_bit),
        .ser_valid(ser_valid), .frame_sync(frame_sync), .I(I),
        .i_valid(i_valid), .i_ready(i_ready), .sync_err(sync_err),
        .overflow(overflow)
`ifdef ADPCM_UNPACK_CNT_EN
        , .word_cnt(word_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Record every handshake and every sync_err pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (i_valid && i_ready) q.push_back(32'(I));
            if (sync_err) errs++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input logic fs);
        ser_bit = b;
        ser_valid = 1'b1;
        frame_sync = fs;
        @(posedge clk);
        #1;
        ser_valid = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic send_word(input logic [4:0] v, input int n, input logic fs);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], fs && (i == n - 1));
    endtask

    task automatic expect_pop(input string tag, input logic [31:0] exp);
        logic [31:0] v;
        v = (q.size() > 0) ? q.pop_front() : 32'hFFFF_FFFF;
        check(tag, v, exp);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        errs = 0;
    endtask

    initial begin
        idle(2);
        reset_dut();
        check("rst_valid", 32'(i_valid), 0);
        check("rst_I", 32'(I), 0);
        check("rst_err", 32'(sync_err), 0);
        check("rst_ovf", 32'(overflow), 0);
`ifdef ADPCM_UNPACK_CNT_EN
        check("rst_cnt", 32'(word_cnt), 0);
`endif

        // 32 kb/s, two contiguous words
        i_ready = 1'b1;
        rate = 2'b10;
        send_word(5'b01011, 4, 1'b1);
        check("t1_valid", 32'(i_valid), 1);
        check("t1_I", 32'(I), 32'h0B);
        send_bit(1'b0, 1'b0);
        check("t1_pulse", 32'(i_valid), 0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        idle(2);
        expect_pop("t1_w0", 32'h0B);
        expect_pop("t1_w1", 32'h06);
        check("t1_extra", 32'(q.size()), 0);
        check("t1_errs", 32'(errs), 0);

        // Every rate, then a rate change without frame_sync keeps 5-bit words
        rate = 2'b00;
        send_word(5'b00011, 2, 1'b1);
        rate = 2'b01;
        send_word(5'b00101, 3, 1'b1);
        rate = 2'b11;
        send_word(5'b10011, 5, 1'b1);
        rate = 2'b00;
        send_word(5'b00111, 5, 1'b0);
        idle(2);
        expect_pop("t2_16k", 32'h03);
        expect_pop("t2_24k", 32'h05);
        expect_pop("t2_40k", 32'h13);
        expect_pop("t2_norelatch", 32'h07);
        check("t2_extra", 32'(q.size()), 0);
        check("t2_errs", 32'(errs), 0);

        // Mid-word resync at 40 kb/s
        rate = 2'b11;
        send_word(5'b00111, 3, 1'b1);
        send_bit(1'b0, 1'b1);
        check("t3_err_on", 32'(sync_err), 1);
        send_bit(1'b0, 1'b0);
        check("t3_err_off", 32'(sync_err), 0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        idle(2);
        expect_pop("t3_word", 32'h01);
        check("t3_extra", 32'(q.size()), 0);
        check("t3_errs", 32'(errs), 1);

        // Backpressure into a full FIFO drops the third word
        i_ready = 1'b0;
        rate = 2'b10;
        send_word(5'd1, 4, 1'b1);
        check("t4_valid", 32'(i_valid), 1);
        check("t4_I0", 32'(I), 1);
        send_word(5'd2, 4, 1'b0);
        check("t4_hold", 32'(I), 1);
        check("t4_ovf0", 32'(overflow), 0);
        send_word(5'd3, 4, 1'b0);
        check("t4_ovf1", 32'(overflow), 1);
        check("t4_hold2", 32'(I), 1);
        i_ready = 1'b1;
        idle(3);
        expect_pop("t4_d0", 1);
        expect_pop("t4_d1", 2);
        check("t4_extra", 32'(q.size()), 0);
        check("t4_sticky", 32'(overflow), 1);
        check("t4_empty", 32'(i_valid), 0);

        // Reset with one stored word and a partial, then HUNT ignores unsynced bits
        i_ready = 1'b0;
        send_word(5'd5, 4, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        reset_dut();
        check("t5_valid", 32'(i_valid), 0);
        check("t5_ovf", 32'(overflow), 0);
        check("t5_I", 32'(I), 0);
        send_word(5'h0F, 4, 1'b0);
        send_word(5'h0F, 4, 1'b0);
        check("t5_hunt", 32'(i_valid), 0);
        rate = 2'b01;
        send_word(5'd3, 3, 1'b1);
        check("t5_lock_v", 32'(i_valid), 1);
        check("t5_lock_I", 32'(I), 3);
        i_ready = 1'b1;
        idle(2);
        expect_pop("t5_word", 3);
        check("t5_extra", 32'(q.size()), 0);

        // Full FIFO with a pop on the push cycle keeps all words
        reset_dut();
        i_ready = 1'b0;
        rate = 2'b10;
        send_word(5'd1, 4, 1'b1);
        send_word(5'd2, 4, 1'b0);
        send_word(5'd1, 3, 1'b0);
        i_ready = 1'b1;
        send_bit(1'b1, 1'b0);
        i_ready = 1'b0;
        check("t4b_ovf", 32'(overflow), 0);
        check("t4b_head", 32'(I), 2);
        check("t4b_valid", 32'(i_valid), 1);
        i_ready = 1'b1;
        idle(3);
        expect_pop("t4b_d0", 1);
        expect_pop("t4b_d1", 2);
        expect_pop("t4b_d2", 3);
        check("t4b_extra", 32'(q.size()), 0);

        // Gapped 24 kb/s word
        reset_dut();
        rate = 2'b01;
        send_bit(1'b1, 1'b1);
        idle(1);
        send_bit(1'b1, 1'b0);
        idle(1);
        send_bit(1'b0, 1'b0);
        check("t6_valid", 32'(i_valid), 1);
        check("t6_I", 32'(I), 6);
        idle(2);
        expect_pop("t6_word", 6);
        check("t6_extra", 32'(q.size()), 0);
`ifdef ADPCM_UNPACK_CNT_EN
        check("t6_cnt", 32'(word_cnt), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
